// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between fetch and load/store; MEM has priority unless it won last time. Reads 3 cycles min, writes 2.
// Commands hold until m_ready; no response timeout; pipe_stall freezes the front end while any access is outstanding.
module imem_dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [MASK_WIDTH-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  m_valid,
    output logic                  m_we,
    output logic [DATA_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [MASK_WIDTH-1:0] m_wmask,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  pipe_stall
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

    state_t state;
    logic   owner_mem;
    logic   last_mem;
    logic   grant_mem;

    // Fetch gets the next slot after a data access so it cannot starve.
    assign grant_mem  = mem_req & ~(last_mem & if_req);
    assign pipe_stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            owner_mem <= 1'b0;
            last_mem  <= 1'b0;
            m_valid   <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wmask   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        owner_mem <= 1'b1;
                        m_addr    <= mem_addr;
                        m_we      <= mem_we;
                        m_wdata   <= mem_wdata;
                        m_wmask   <= mem_we ? mem_wmask : '0;
                        m_valid   <= 1'b1;
                        state     <= ISSUE;
                    end else if (if_req) begin
                        owner_mem <= 1'b0;
                        m_addr    <= if_addr;
                        m_we      <= 1'b0;
                        m_wdata   <= '0;
                        m_wmask   <= '0;
                        m_valid   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (m_we) begin
                            state <= RESP;
                            if (owner_mem) mem_ready <= 1'b1;
                            else           if_ready  <= 1'b1;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (m_rvalid) begin
                        state <= RESP;
                        if (owner_mem) begin
                            mem_rdata <= m_rdata;
                            mem_ready <= 1'b1;
                        end else begin
                            if_rdata <= m_rdata;
                            if_ready <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Requesters update at the end of this cycle, so arbitration waits for IDLE.
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    last_mem  <= owner_mem;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed requesters push expected responses/commands;
// a monitor and a memory responder pop and compare them.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ready, mem_ready;
    logic        m_valid, m_we, m_ready, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wmask;
    logic        pipe_stall;

    imem_dmem_arbiter #(.DATA_WIDTH(32), .MASK_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] data; int cyc;} exp_t;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;} cmd_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    cmd_t cmd_q[$];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int acc_dly = 0;
    int rv_dly  = 0;
    bit stray_rv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_2004: return 32'h1111_2222;
            32'h0000_2008: return 32'h3333_4444;
            32'h0000_3000: return 32'hCAFE_F00D;
            default:       return 32'h0;
        endcase
    endfunction

    // Response monitor
    logic prev_if_ready = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (if_ready) begin
                    chk("if_ready_not_back_to_back", {71'd0, prev_if_ready}, 72'd0);
                    if (if_q.size() == 0) begin
                        chk("if_ready_unexpected", 72'd1, 72'd0);
                    end else begin
                        e = if_q.pop_front();
                        chk("if_rdata", {40'd0, if_rdata}, {40'd0, e.data});
                        if (e.cyc >= 0) chk("if_ready_cycle", 72'(cyc), 72'(e.cyc));
                    end
                end
                if (mem_ready) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_ready_unexpected", 72'd1, 72'd0);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_rdata", {40'd0, mem_rdata}, {40'd0, e.data});
                        if (e.cyc >= 0) chk("mem_ready_cycle", 72'(cyc), 72'(e.cyc));
                    end
                end
                if (if_ready && mem_ready) chk("one_ready_at_a_time", 72'd1, 72'd0);
                prev_if_ready = if_ready;
            end else begin
                prev_if_ready = 1'b0;
            end
        end
    end

    // Memory responder: checks each command, holds m_ready off for acc_dly cycles, returns reads rv_dly later
    initial begin
        bit          rv_pend = 1'b0, snap_ok = 1'b0;
        int          rv_cnt = 0, wait_cnt = 0;
        logic [31:0] rd_addr = '0;
        cmd_t        snap, e;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '1;
                rv_pend = 1'b0; wait_cnt = 0; snap_ok = 1'b0;
            end else begin
                m_rvalid = 1'b0; m_rdata = '1;
                if (rv_pend) begin
                    if (rv_cnt == 0) begin
                        m_rvalid = 1'b1; m_rdata = mem_word(rd_addr); rv_pend = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end else if (stray_rv && m_valid) begin
                    m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
                end
                if (!m_valid) begin
                    m_ready = 1'b0; wait_cnt = 0; snap_ok = 1'b0;
                end else begin
                    if (!snap_ok) begin
                        snap = {m_we, m_addr, m_wdata, m_wmask};
                        snap_ok = 1'b1;
                        if (cmd_q.size() == 0) begin
                            chk("cmd_unexpected", 72'd1, 72'd0);
                        end else begin
                            e = cmd_q.pop_front();
                            chk("cmd_we",    {71'd0, m_we},    {71'd0, e.we});
                            chk("cmd_addr",  {40'd0, m_addr},  {40'd0, e.addr});
                            chk("cmd_wmask", {68'd0, m_wmask}, {68'd0, e.wmask});
                            if (e.we) chk("cmd_wdata", {40'd0, m_wdata}, {40'd0, e.wdata});
                        end
                    end else begin
                        chk("cmd_held", {3'd0, m_we, m_addr, m_wdata, m_wmask}, {3'd0, snap});
                    end
                    if (wait_cnt == acc_dly) begin
                        m_ready = 1'b1;
                        if (!m_we) begin
                            rv_pend = 1'b1; rv_cnt = rv_dly; rd_addr = m_addr;
                        end
                    end else begin
                        m_ready = 1'b0; wait_cnt++;
                    end
                end
            end
        end
    end

    // Requesters: called aligned 1 time unit after a rising edge; return aligned the same way.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, input int lat,
                            input bit push_cmd, input bit chk_stall);
        int n = 0;
        if_req = 1'b1; if_addr = addr;
        if_q.push_back('{exp, cyc + lat});
        if (push_cmd) cmd_q.push_back({1'b0, addr, 32'd0, 4'd0});
        forever begin
            @(negedge clk);
            if (chk_stall) chk(if_ready ? "stall_low_in_resp" : "stall_high_busy",
                               {71'd0, pipe_stall}, {71'd0, !if_ready});
            if (if_ready) break;
            if (++n > 200) begin chk("if_ready_timeout", 72'd1, 72'd0); break; end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [31:0] exp, input int lat,
                          input bit push_cmd);
        int n = 0;
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask;
        mem_q.push_back('{exp, cyc + lat});
        if (push_cmd) cmd_q.push_back({we, addr, we ? wdata : 32'd0, we ? wmask : 4'd0});
        forever begin
            @(negedge clk);
            if (mem_ready) break;
            if (++n > 200) begin chk("mem_ready_timeout", 72'd1, 72'd0); break; end
        end
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        #3;
        chk("reset_outputs", {3'd0, m_valid, m_we, m_addr, m_wdata, m_wmask}, 72'd0);
        chk("reset_rdata",   {8'd0, if_rdata, mem_rdata}, 72'd0);
        chk("reset_ready",   {69'd0, if_ready, mem_ready, pipe_stall}, 72'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Single fetch, zero-wait memory: ready in cycle 3, stall tracked every cycle
        acc_dly = 0; rv_dly = 0;
        do_fetch(32'h100, 32'h0050_0093, 3, 1'b1, 1'b1);
        @(negedge clk);
        chk("stall_idle", {71'd0, pipe_stall}, 72'd0);
        @(posedge clk); #1;

        // Contention: MEM 0x2004 first, then IF (fairness), then MEM 0x2008
        cmd_q.push_back({1'b0, 32'h2004, 32'd0, 4'd0});
        cmd_q.push_back({1'b0, 32'h100,  32'd0, 4'd0});
        cmd_q.push_back({1'b0, 32'h2008, 32'd0, 4'd0});
        fork
            do_fetch(32'h100, 32'h0050_0093, 7, 1'b0, 1'b0);
            begin
                do_mem(1'b0, 32'h2004, 32'h5555_AAAA, 4'hF, 32'h1111_2222, 3, 1'b0);
                do_mem(1'b0, 32'h2008, 32'h5555_AAAA, 4'hF, 32'h3333_4444, 7, 1'b0);
            end
        join

        // Store with m_ready held off 3 cycles; mem_rdata keeps the last load
        acc_dly = 3;
        do_mem(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 32'h3333_4444, 5, 1'b1);

        // Wait-state read with stray m_rvalid during ISSUE
        acc_dly = 2; rv_dly = 4; stray_rv = 1'b1;
        do_mem(1'b0, 32'h3000, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 9, 1'b1);
        stray_rv = 1'b0;

        // Back-to-back fetches: ready pulses 4 cycles apart
        acc_dly = 0; rv_dly = 0;
        do_fetch(32'h100, 32'h0050_0093, 3, 1'b1, 1'b0);
        do_fetch(32'h104, 32'h00A0_0113, 3, 1'b1, 1'b0);

        // Reset while waiting for read data
        rv_dly = 20;
        if_req = 1'b1; if_addr = 32'h104;
        cmd_q.push_back({1'b0, 32'h104, 32'd0, 4'd0});
        repeat (4) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("midreset_outputs", {3'd0, m_valid, m_we, m_addr, m_wdata, m_wmask}, 72'd0);
        chk("midreset_rdata",   {8'd0, if_rdata, mem_rdata}, 72'd0);
        chk("midreset_ready",   {70'd0, if_ready, mem_ready}, 72'd0);
        @(posedge clk); #1;
        if_addr = 32'h100; rv_dly = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        do_fetch(32'h100, 32'h0050_0093, 3, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        chk("queues_drained", 72'(if_q.size() + mem_q.size() + cmd_q.size()), 72'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
